// File: rtl/rr_arbiter4_pkg.sv
// Shared types and the round-robin winner search for rr_arbiter4.
package rr_arbiter4_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Result of an arbitration: whether anyone was requesting, and who won.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first valid requester wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                    input logic [1:0]      ptr);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + 2'(i);
      if (!p.found && valid[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter4_mux4.sv
// Four-way payload multiplexer selected by an encoded index.
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select; no pipelining on the data path.
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin packet arbiter; a grant is held from the
// first beat of a packet through the beat flagged last.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy
);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] next_ptr;
  pick_t      idle_pick;
  pick_t      rearb_pick;
  logic       last_accept;

  // Arbitration candidates: from ptr while idle, and from the rotated
  // pointer when the current packet ends this cycle.
  always_comb begin
    next_ptr    = sel + 2'd1;
    idle_pick   = rr_pick(req_valid, ptr);
    rearb_pick  = rr_pick(req_valid, next_ptr);
    last_accept = out_valid && out_ready && out_last;
  end

  // Grant-side outputs decode directly from sel while a packet is granted.
  always_comb begin
    gnt       = '0;
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (state == GRANT) begin
      busy           = 1'b1;
      gnt[sel]       = 1'b1;
      req_ready[sel] = out_ready;
      out_valid      = req_valid[sel];
      out_last       = req_last[sel];
    end
  end

  // Control FSM: arbitrate from IDLE, hold grant through the packet, and
  // re-arbitrate on the last accepted beat so back-to-back packets have no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick.found) begin
            sel   <= idle_pick.idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (last_accept) begin
            ptr <= next_ptr;
            if (rearb_pick.found) begin
              sel <= rearb_pick.idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux4 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .d0 (req_data0),
    .d1 (req_data1),
    .d2 (req_data2),
    .d3 (req_data3),
    .sel(sel),
    .y  (out_data)
  );

endmodule
